// File: rtl/arb2_mux_stage.sv
// arb2_mux_stage: two-source round-robin arbiter feeding a single-entry
// valid/ready output register. y_sel records which source supplied y_data
// (0 = A, 1 = B) so downstream bus logic can use it directly as a mux select.
module arb2_mux_stage #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [N-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [N-1:0] b_data,
  output logic         b_ready,
  output logic         y_valid,
  output logic [N-1:0] y_data,
  output logic         y_sel,
  input  logic         y_ready
);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  src_t last_grant;
  logic accept;
  logic grant_a;
  logic grant_b;

  // Grant decision: only when the output slot is empty or draining this cycle;
  // on contention the source that did not win last time goes next.
  always_comb begin
    accept  = !y_valid || y_ready;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (accept) begin
      if (a_valid && b_valid) begin
        if (last_grant == SRC_A) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
      end else if (a_valid) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Output register and priority state; last_grant starts at B so A wins the
  // first contention, and it only moves on an actual transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid    <= 1'b0;
      y_data     <= '0;
      y_sel      <= 1'b0;
      last_grant <= SRC_B;
    end else if (accept) begin
      if (grant_a || grant_b) begin
        y_valid    <= 1'b1;
        y_data     <= grant_b ? b_data : a_data;
        y_sel      <= grant_b;
        last_grant <= grant_b ? SRC_B : SRC_A;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb2_mux_stage.sv
// Directed bench for arb2_mux_stage: reset, A-only streaming, priority
// bookkeeping, contention alternation, backpressure and mid-stream reset.
module tb_arb2_mux_stage;

  localparam int unsigned N = 8;

  logic         clk;
  logic         rst;
  logic         a_valid;
  logic [N-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [N-1:0] b_data;
  logic         b_ready;
  logic         y_valid;
  logic [N-1:0] y_data;
  logic         y_sel;
  logic         y_ready;

  int unsigned n_cmp;
  int unsigned n_bad;

  arb2_mux_stage #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_sel   (y_sel),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdy(input string tag, input logic ea, input logic eb);
    chk({tag, ".a_ready"}, {31'd0, a_ready}, {31'd0, ea});
    chk({tag, ".b_ready"}, {31'd0, b_ready}, {31'd0, eb});
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [N-1:0] ed, input logic es);
    chk({tag, ".y_valid"}, {31'd0, y_valid}, {31'd0, ev});
    chk({tag, ".y_data"},  {24'd0, y_data},  {24'd0, ed});
    chk({tag, ".y_sel"},   {31'd0, y_sel},   {31'd0, es});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b0;
    a_valid = 1'b0;
    a_data  = '0;
    b_valid = 1'b0;
    b_data  = '0;
    y_ready = 1'b1;

    // asynchronous reset before any clock edge
    #3 rst = 1'b1;
    #1 chk_out("rst_async", 1'b0, 8'h00, 1'b0);
    tick();
    rst = 1'b0;
    a_valid = 1'b1; a_data = 8'h01;
    #1 chk_rdy("post_rst", 1'b1, 1'b0);
    tick();
    chk_out("first_word", 1'b1, 8'h01, 1'b0);

    // A only, back-to-back
    a_data = 8'h02;
    #1 chk_rdy("a_only2", 1'b1, 1'b0);
    tick();
    chk_out("a_only2", 1'b1, 8'h02, 1'b0);
    a_data = 8'h03;
    #1 chk_rdy("a_only3", 1'b1, 1'b0);
    tick();
    chk_out("a_only3", 1'b1, 8'h03, 1'b0);
    a_valid = 1'b0;
    #1 chk_rdy("idle", 1'b0, 1'b0);
    tick();
    chk_out("idle", 1'b0, 8'h03, 1'b0);

    // B alone moves priority to B, so the following contention starts with A
    b_valid = 1'b1; b_data = 8'h33;
    #1 chk_rdy("b_alone", 1'b0, 1'b1);
    tick();
    chk_out("b_alone", 1'b1, 8'h33, 1'b1);

    // contention: alternation A,B,A,B
    a_valid = 1'b1; a_data = 8'hA0; b_data = 8'hB0;
    #1 chk_rdy("cont0", 1'b1, 1'b0);
    tick();
    chk_out("cont0", 1'b1, 8'hA0, 1'b0);
    a_data = 8'hA1;
    #1 chk_rdy("cont1", 1'b0, 1'b1);
    tick();
    chk_out("cont1", 1'b1, 8'hB0, 1'b1);
    b_data = 8'hB1;
    #1 chk_rdy("cont2", 1'b1, 1'b0);
    tick();
    chk_out("cont2", 1'b1, 8'hA1, 1'b0);
    a_data = 8'hA2;
    #1 chk_rdy("cont3", 1'b0, 1'b1);
    tick();
    chk_out("cont3", 1'b1, 8'hB1, 1'b1);
    b_data = 8'hB2;

    // load C1 from A (last grant was B), then stall for 3 cycles
    a_data = 8'hC1;
    tick();
    chk_out("bp_load", 1'b1, 8'hC1, 1'b0);
    a_data = 8'hC2;
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk_rdy("bp_stall", 1'b0, 1'b0);
      tick();
      chk_out("bp_stall", 1'b1, 8'hC1, 1'b0);
    end
    y_ready = 1'b1;
    #1 chk_rdy("bp_release", 1'b0, 1'b1);
    tick();
    chk_out("bp_release", 1'b1, 8'hB2, 1'b1);
    b_data = 8'hB3;

    // mid-stream reset: output drops at once, A wins first after release
    #1 rst = 1'b1;
    #1 chk_out("rst_mid", 1'b0, 8'h00, 1'b0);
    tick();
    chk_out("rst_hold", 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    #1 chk_rdy("rst_rel", 1'b1, 1'b0);
    tick();
    chk_out("rst_rel", 1'b1, 8'hC2, 1'b0);
    #1 chk_rdy("rst_rel_next", 1'b0, 1'b1);
    tick();
    chk_out("rst_rel_next", 1'b1, 8'hB3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arb2_mux_stage.md
# arb2_mux_stage

Two-source, round-robin arbitrated input stage for the N-bit data bus multiplexer. It accepts words from two independent valid/ready sources A and B and picks one per cycle by round-robin. It registers the winning word together with its select bit into a single-entry output register with a valid/ready interface. `y_sel` is the registered equivalent of the mux `sel` input: 0 means the word came from A, 1 means it came from B. Downstream bus logic consumes the block's output directly.

## Interface
- `N`, default 8: data bus width in bits. Must be ≥ 1.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset: one clock; asynchronous, active-high.
- `a_valid`  in  1  source A presents a word.
- `a_data`  in  N  source A word.
- `a_ready`  out  1  A word accepted this cycle (`a_valid && a_ready` means transfer).
- `b_valid`  in  1  source B presents a word.
- `b_data`  in  N  source B word.
- `b_ready`  out  1  B word accepted this cycle.
- `y_valid`  out  1  output register holds a word.
- `y_data`  out  N  registered selected word.
- `y_sel`  out  1  source of `y_data`: 0 = A, 1 = B.
- `y_ready`  in  1  downstream consumes `y_data` this cycle.

## Operation
- Internal state:
  - `last_grant` (1 bit): source of the most recent accepted word.
  - Output register: `y_valid`, `y_data`, `y_sel`.
- `accept = !y_valid || y_ready`. The register is either empty or being drained this cycle.
- Grant, combinational, evaluated only when `accept` is 1:
  - Only `a_valid` asserted: grant A.
  - Only `b_valid` asserted: grant B.
  - Both asserted: grant the source ≠ `last_grant` (strict alternation).
  - Neither asserted: no grant.
- Ready outputs:
  - `a_ready = accept && grant_A`.
  - `b_ready = accept && grant_B`.
  - At most one ready is high in any cycle.
  - A ready never rises for a source whose valid is low.
- On a clock edge with a grant:
  - `y_data <=` granted data.
  - `y_sel <=` granted source.
  - `y_valid <= 1`.
  - `last_grant <=` granted source.
- On a clock edge with `accept` high and no grant: `y_valid <= 0`. `y_data`, `y_sel` and `last_grant` hold.
- On a clock edge with `y_valid && !y_ready` (stall): all state holds, and both readys are 0.
- Sources obey the valid/ready rule: once valid is asserted, data holds until the transfer. The block does not check this.
- `last_grant` changes only on an actual transfer. An idle source never consumes a priority turn.

## Timing
- Reset (asynchronous, immediate, independent of `clk`):
  - `y_valid = 0`, `y_data = 0`, `y_sel = 0`.
  - `last_grant = 1`, so A wins the first contention.
  - `a_ready` and `b_ready` read 1 only through the combinational path when their valid is high, because `accept` = 1 after reset.
- Latency: a word accepted at edge k appears on `y_data`/`y_valid` immediately after edge k. That is 1 cycle from input transfer to output valid.
- Throughput: one word per cycle when `y_ready` is held high. There are no bubbles under continuous demand.
- Drain and refill: if `y_valid && y_ready` and a source is valid in the same cycle, the old word leaves and the new word loads on the same edge.
- Contention under full throughput: the output sequence alternates A,B,A,B… as long as both valids stay high.
- Reset asserted mid-stream: any held word is discarded and `y_valid` drops immediately. Any transfer in flight on that edge is lost. After release, priority restarts with A first.
- Ready paths are combinational from `a_valid`, `b_valid` and `y_ready`. No combinational path runs from `y_ready` to `y_data`.

## Test plan
- Reset: assert `rst` between edges, with no clock needed -> `y_valid=0`, `y_data=8'h00`, `y_sel=0` immediately. After release, drive `a_valid=1` with `a_data=8'h01` -> `a_ready=1`, and the next edge gives `y_data=8'h01`, `y_sel=0`.
- A only, `y_ready=1`: drive `8'h01`,`8'h02`,`8'h03` on consecutive cycles -> the same values appear on `y_data` one cycle later, back-to-back, `y_sel=0`, `b_ready=0` throughout.
- Contention: both valid continuously, with `a_data=8'hA0`, `b_data=8'hB0` updated on each transfer, `y_ready=1` -> `y_sel` sequence 0,1,0,1, each source's ready high on alternate cycles.
- Backpressure: `y_valid=1` holding `8'hC1`, `y_ready=0` for 3 cycles while both sources are valid -> `y_data` stays `8'hC1`, `a_ready=b_ready=0`. When `y_ready` rises, the next word loads on the same edge.
- Priority bookkeeping: B alone transfers `8'h33`, then both become valid -> A is granted next (`y_sel=0`), then B.
- Reset mid-operation: contention running with `y_valid=1`; pulse `rst` for 1 cycle -> `y_valid` falls at once. After release, the first contention grants A.
